rc5_enc_ctrl: RTL and testbench

RC5_ENC_CTRL -- requirements
Module: rc5_enc_ctrl

---
 rtl/rc5_enc_ctrl_pkg.sv | 15 +
 rtl/rc5_enc_ctrl_if.sv | 23 ++
 rtl/rc5_enc_ctrl_rotl.sv | 14 +
 rtl/rc5_enc_ctrl.sv | 98 +++++++++
 tb/tb_rc5_enc_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rc5_enc_ctrl_pkg.sv
// Shared constants and FSM state type for the RC5 encryption controller.
package rc5_pkg;
  localparam int WORD_W = 16;
  localparam int ROT_W  = 4;
  localparam int KEY_AW = 8;

  typedef enum logic [2:0] {
    IDLE,
    PRE_A,
    PRE_B,
    RND_A,
    RND_B,
    DONE
  } state_t;
endpackage

// File: rtl/rc5_enc_ctrl_if.sv
// Plaintext-in / ciphertext-out handshake bundle; names are from the controller's view.
interface rc5_enc_ctrl_if;
  import rc5_pkg::*;

  logic              in_valid_i;
  logic              in_ready_o;
  logic [WORD_W-1:0] pt_a_i;
  logic [WORD_W-1:0] pt_b_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [WORD_W-1:0] ct_a_o;
  logic [WORD_W-1:0] ct_b_o;

  modport master (
    output in_valid_i, pt_a_i, pt_b_i, out_ready_i,
    input  in_ready_o, out_valid_o, ct_a_o, ct_b_o
  );

  modport slave (
    input  in_valid_i, pt_a_i, pt_b_i, out_ready_i,
    output in_ready_o, out_valid_o, ct_a_o, ct_b_o
  );
endinterface

// File: rtl/rc5_enc_ctrl_rotl.sv
// Data-dependent left rotate of one RC5 word by a ROT_W-bit amount.
module rc5_enc_ctrl_rotl
  import rc5_pkg::*;
(
  input  logic [WORD_W-1:0] data_i,
  input  logic [ROT_W-1:0]  n_i,
  output logic [WORD_W-1:0] data_o
);
  logic [ROT_W:0] rs;

  // A zero amount yields a right shift by the full width, which contributes nothing.
  assign rs     = (ROT_W+1)'(WORD_W) - {1'b0, n_i};
  assign data_o = (data_i << n_i) | (data_i >> rs);
endmodule

// File: rtl/rc5_enc_ctrl.sv
// RC5 block encryption controller: one expanded-key word consumed per compute cycle.
module rc5_enc_ctrl #(
  parameter int NUM_ROUNDS = 12,
  parameter int WORD_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  rc5_enc_ctrl_if.slave               io,
  output logic [rc5_pkg::KEY_AW-1:0]  key_addr_o,
  input  logic [WORD_W-1:0]           key_data_i,
  output logic                        busy_o
);
  import rc5_pkg::*;

  localparam logic [KEY_AW-1:0] K_LAST = KEY_AW'(2 * NUM_ROUNDS + 1);

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   a_q, a_d, b_q, b_d;
  logic [KEY_AW-1:0]   k_q, k_d;
  logic                init_q;
  logic [WORD_W-1:0]   rot_data, rot_out;
  logic [ROT_W-1:0]    rot_n;

  // Single shared rotator: only the amount source differs between the half-rounds.
  assign rot_data = a_q ^ b_q;
  assign rot_n    = (state_q == RND_B) ? a_q[ROT_W-1:0] : b_q[ROT_W-1:0];

  rc5_enc_ctrl_rotl u_rotl (
    .data_i (rot_data),
    .n_i    (rot_n),
    .data_o (rot_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      init_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (io.in_valid_i && init_q) begin
          a_d     = io.pt_a_i;
          b_d     = io.pt_b_i;
          k_d     = '0;
          state_d = PRE_A;
        end
      end
      PRE_A: begin
        a_d     = a_q + key_data_i;
        k_d     = k_q + 1'b1;
        state_d = PRE_B;
      end
      PRE_B: begin
        b_d     = b_q + key_data_i;
        k_d     = k_q + 1'b1;
        state_d = RND_A;
      end
      RND_A: begin
        a_d     = rot_out + key_data_i;
        k_d     = k_q + 1'b1;
        state_d = RND_B;
      end
      RND_B: begin
        b_d     = rot_out + key_data_i;
        k_d     = k_q + 1'b1;
        state_d = (k_q == K_LAST) ? DONE : RND_A;
      end
      DONE: begin
        if (io.out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // init_q keeps in_ready low until the first edge after reset release.
  assign io.in_ready_o  = (state_q == IDLE) && init_q;
  assign io.out_valid_o = (state_q == DONE);
  assign io.ct_a_o      = (state_q == DONE) ? a_q : '0;
  assign io.ct_b_o      = (state_q == DONE) ? b_q : '0;
  assign busy_o         = (state_q != IDLE);
  assign key_addr_o     = (state_q == IDLE || state_q == DONE) ? '0 : k_q;
endmodule

// File: tb/tb_rc5_enc_ctrl.sv
// Self-checking bench: directed and randomized blocks against a plain-arithmetic RC5 model.
module tb_rc5_enc_ctrl;
  logic        clk;
  logic        rst_n;
  logic [7:0]  key_addr, key_addr1;
  logic [15:0] key_data, key_data1;
  logic        busy, busy1;
  logic [15:0] key_mem [256];
  int          n_pass;
  int          n_total;

  rc5_enc_ctrl_if io ();
  rc5_enc_ctrl_if io1 ();

  rc5_enc_ctrl #(.NUM_ROUNDS(12), .WORD_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .io(io.slave),
    .key_addr_o(key_addr), .key_data_i(key_data), .busy_o(busy)
  );

  rc5_enc_ctrl #(.NUM_ROUNDS(1), .WORD_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .io(io1.slave),
    .key_addr_o(key_addr1), .key_data_i(key_data1), .busy_o(busy1)
  );

  assign key_data  = key_mem[key_addr];
  assign key_data1 = (key_addr1 < 8'd4) ? 16'(key_addr1 + 8'd1) : 16'h0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic int unsigned rotl16(input int unsigned x, input int unsigned r);
    return ((x << r) | (x >> (16 - r))) & 32'hFFFF;
  endfunction

  // Textbook RC5 encryption over the 12-round key table.
  function automatic logic [31:0] ref_enc(input logic [15:0] pa, input logic [15:0] pb);
    int unsigned a, b;
    a = (32'(pa) + 32'(key_mem[0])) & 32'hFFFF;
    b = (32'(pb) + 32'(key_mem[1])) & 32'hFFFF;
    for (int i = 1; i <= 12; i++) begin
      a = (rotl16(a ^ b, b % 16) + 32'(key_mem[2*i])) & 32'hFFFF;
      b = (rotl16(b ^ a, a % 16) + 32'(key_mem[2*i+1])) & 32'hFFFF;
    end
    return {a[15:0], b[15:0]};
  endfunction

  task automatic randomize_keys();
    for (int i = 0; i < 256; i++) key_mem[i] = 16'($urandom);
  endtask

  // Called at a negedge with the controller idle; returns just after the accepting edge.
  task automatic accept_block(input logic [15:0] a, input logic [15:0] b);
    io.in_valid_i = 1'b1;
    io.pt_a_i     = a;
    io.pt_b_i     = b;
    chk("in_ready_idle", 32'(io.in_ready_o), 32'd1);
    @(posedge clk);
    #1 io.in_valid_i = 1'b0;
  endtask

  // Follows the block to DONE, checking the key index walk and the latency.
  task automatic wait_done(input logic [31:0] exp_ct);
    int cnt = 0;
    int idx = 0;
    while (1) begin
      @(negedge clk);
      if (io.out_valid_o) break;
      chk("key_addr_seq", 32'(key_addr), 32'(idx));
      idx++;
      if (cnt >= 300) break;
      @(posedge clk);
      cnt++;
    end
    chk("latency", 32'(cnt), 32'd26);
    chk("ct_a", 32'(io.ct_a_o), 32'(exp_ct[31:16]));
    chk("ct_b", 32'(io.ct_b_o), 32'(exp_ct[15:0]));
  endtask

  // Stalls the consumer for bp cycles while poking in_valid, then completes the handshake.
  task automatic release_out(input int bp, input logic [31:0] exp_ct);
    for (int i = 0; i < bp; i++) begin
      io.out_ready_i = 1'b0;
      io.in_valid_i  = i[0];
      io.pt_a_i      = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("bp_valid", 32'(io.out_valid_o), 32'd1);
      chk("bp_ready", 32'(io.in_ready_o), 32'd0);
      chk("bp_ct_a", 32'(io.ct_a_o), 32'(exp_ct[31:16]));
      chk("bp_ct_b", 32'(io.ct_b_o), 32'(exp_ct[15:0]));
    end
    io.in_valid_i  = 1'b0;
    io.out_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io.out_ready_i = 1'b0;
    chk("rel_valid", 32'(io.out_valid_o), 32'd0);
    chk("rel_ready", 32'(io.in_ready_o), 32'd1);
    chk("rel_busy", 32'(busy), 32'd0);
    chk("rel_ct_a", 32'(io.ct_a_o), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_ct, exp_ct2;
    logic [15:0] pa, pb;
    int          waited, seen_valid;
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    io.in_valid_i = 1'b0; io.pt_a_i = '0; io.pt_b_i = '0; io.out_ready_i = 1'b0;
    io1.in_valid_i = 1'b0; io1.pt_a_i = '0; io1.pt_b_i = '0; io1.out_ready_i = 1'b0;
    for (int i = 0; i < 256; i++) key_mem[i] = '0;

    // Reset state
    #1;
    chk("rst_in_ready", 32'(io.in_ready_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(io.out_valid_o), 32'd0);
    chk("rst_key_addr", 32'(key_addr), 32'd0);
    chk("rst_ct", 32'({io.ct_a_o, io.ct_b_o}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rdy_before_edge", 32'(io.in_ready_o), 32'd0);
    @(negedge clk);
    chk("rdy_after_edge", 32'(io.in_ready_o), 32'd1);

    // One-round instance with S = {1,2,3,4}
    io1.in_valid_i = 1'b1;
    @(posedge clk);
    #1 io1.in_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("n1_key_addr", 32'(key_addr1), 32'(i));
      chk("n1_valid_low", 32'(io1.out_valid_o), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("n1_valid", 32'(io1.out_valid_o), 32'd1);
    chk("n1_ct_a", 32'(io1.ct_a_o), 32'h000F);
    chk("n1_ct_b", 32'(io1.ct_b_o), 32'h800A);
    io1.out_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io1.out_ready_i = 1'b0;
    chk("n1_released", 32'(io1.out_valid_o), 32'd0);

    // All-zero key and plaintext
    exp_ct = ref_enc(16'h0, 16'h0);
    accept_block(16'h0, 16'h0);
    wait_done(exp_ct);
    chk("zero_ct", 32'({io.ct_a_o, io.ct_b_o}), 32'h0);
    release_out(0, exp_ct);

    // Randomized blocks with varying short stalls
    for (int t = 0; t < 4; t++) begin
      randomize_keys();
      pa = 16'($urandom);
      pb = 16'($urandom);
      exp_ct = ref_enc(pa, pb);
      accept_block(pa, pb);
      wait_done(exp_ct);
      release_out(int'($urandom_range(0, 2)), exp_ct);
    end

    // Five-cycle backpressure with in_valid pulses in DONE
    randomize_keys();
    pa = 16'($urandom);
    pb = 16'($urandom);
    exp_ct = ref_enc(pa, pb);
    accept_block(pa, pb);
    wait_done(exp_ct);
    release_out(5, exp_ct);

    // B = 0x0010 entering the first RND_A: only the low nibble selects the rotation
    randomize_keys();
    key_mem[1] = 16'h0010;
    pa = 16'($urandom);
    exp_ct = ref_enc(pa, 16'h0000);
    accept_block(pa, 16'h0000);
    wait_done(exp_ct);
    release_out(1, exp_ct);

    // Reset at RND_B of round 5 (key index 11)
    randomize_keys();
    accept_block(16'($urandom), 16'($urandom));
    waited = 0;
    while (waited < 50) begin
      @(negedge clk);
      if (key_addr == 8'd11) break;
      waited++;
    end
    chk("mid_key_addr", 32'(key_addr), 32'd11);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(io.out_valid_o), 32'd0);
    chk("mid_rst_ready", 32'(io.in_ready_o), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_key_addr", 32'(key_addr), 32'd0);
    chk("mid_rst_ct", 32'({io.ct_a_o, io.ct_b_o}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (io.out_valid_o) seen_valid++;
    end
    chk("no_partial_ct", 32'(seen_valid), 32'd0);
    pa = 16'($urandom);
    pb = 16'($urandom);
    exp_ct = ref_enc(pa, pb);
    accept_block(pa, pb);
    wait_done(exp_ct);
    release_out(0, exp_ct);

    // Back-to-back blocks: re-accept one cycle after the output handshake
    randomize_keys();
    pa = 16'($urandom);
    pb = 16'($urandom);
    exp_ct = ref_enc(pa, pb);
    accept_block(pa, pb);
    wait_done(exp_ct);
    pa = 16'($urandom);
    pb = 16'($urandom);
    exp_ct2 = ref_enc(pa, pb);
    io.in_valid_i  = 1'b1;
    io.pt_a_i      = pa;
    io.pt_b_i      = pb;
    io.out_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_valid_low", 32'(io.out_valid_o), 32'd0);
    chk("b2b_ready", 32'(io.in_ready_o), 32'd1);
    @(posedge clk);
    #1;
    io.in_valid_i  = 1'b0;
    io.out_ready_i = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done(exp_ct2);
    release_out(0, exp_ct2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
